// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_unit_pkg
// Brief  : ALU op codes and decode helpers shared by EX and the divider.
// Rev    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    localparam int         c_ALU_OP_W = 5;
    localparam logic [4:0] c_ALU_DIV  = 5'b11010;
    localparam logic [4:0] c_ALU_DIVU = 5'b11011;

    function automatic logic isDivStart(input logic [c_ALU_OP_W-1:0] aluControl,
                                        input logic                  hiloEn);
        return ((aluControl == c_ALU_DIV) || (aluControl == c_ALU_DIVU)) && hiloEn;
    endfunction

    function automatic logic isDivSigned(input logic [c_ALU_OP_W-1:0] aluControl);
        return aluControl == c_ALU_DIV;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module : div_unit_if
// Brief  : EX-stage divide request / HI-LO result bundle.
// Rev    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             stall_o;
    logic             ready_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, signed_i, a_i, b_i, cancel_i,
        input  stall_o, ready_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i, cancel_i,
        output stall_o, ready_o, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module : div_unit
// Brief  : Iterative radix-2 restoring divider for MIPS DIV/DIVU (LO=quo, HI=rem).
// Rev    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    div_unit_if.slave   bus
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_absB;
    logic               r_negQ;
    logic               r_negR;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_divZero;
    logic               w_lastBit;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH:0]     w_shRem;
    logic [WIDTH-1:0]   w_shQuo;
    logic [WIDTH+1:0]   w_diff;
    logic [WIDTH:0]     w_remNext;
    logic [WIDTH-1:0]   w_quoNext;

    assign w_accept  = bus.start_i & ~bus.cancel_i;
    assign w_divZero = (bus.b_i == '0);
    assign w_lastBit = (r_count == c_CNT_W'(WIDTH - 1));
    assign w_absA    = (bus.signed_i & bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    assign w_absB    = (bus.signed_i & bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

    // Shift {rem,quo} left one place, then try to subtract the divisor; a
    // clear borrow bit means the trial remainder is non-negative.
    assign w_shRem   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_shQuo   = {r_quo[WIDTH-2:0], 1'b0};
    assign w_diff    = {1'b0, w_shRem} - {2'b00, r_absB};
    assign w_remNext = w_diff[WIDTH+1] ? w_shRem : w_diff[WIDTH:0];
    assign w_quoNext = {w_shQuo[WIDTH-1:1], ~w_diff[WIDTH+1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        bus.stall_o = bus.start_i & (r_state != DONE) & ~bus.cancel_i;
        bus.ready_o = (r_state == DONE);
        case (r_state)
            IDLE:    if (w_accept) w_stateNext = w_divZero ? DZERO : BUSY;
            BUSY:    if (bus.cancel_i) w_stateNext = IDLE;
                     else if (w_lastBit) w_stateNext = DONE;
            DZERO:   w_stateNext = bus.cancel_i ? IDLE : DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_absB  <= '0;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= '0;
                        r_rem   <= '0;
                        // Divide-by-zero returns the raw dividend in HI, so keep it unsigned-as-is.
                        r_quo   <= w_divZero ? bus.a_i : w_absA;
                        r_absB  <= w_absB;
                        r_negQ  <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                        r_negR  <= bus.signed_i & bus.a_i[WIDTH-1];
                    end
                end
                BUSY: begin
                    r_count <= r_count + 1'b1;
                    r_rem   <= w_remNext;
                    r_quo   <= w_quoNext;
                    if (w_lastBit && !bus.cancel_i) begin
                        r_lo <= r_negQ ? -w_quoNext : w_quoNext;
                        r_hi <= r_negR ? -w_remNext[WIDTH-1:0] : w_remNext[WIDTH-1:0];
                    end
                end
                DZERO: begin
                    if (!bus.cancel_i) begin
                        r_lo <= '1;
                        r_hi <= r_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_o = r_hi;
    assign bus.lo_o = r_lo;

endmodule
`default_nettype wire
